// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared types and helpers for the universal shift register.
//
// Contents
//   mode_t      : operating modes as presented on the 3-bit mode port
//   state_t     : counted-shift controller states
//   sel_t       : per-bit next-value select used by usr_cell
//   decode_mode : maps the raw 3-bit mode port onto mode_t (6/7 -> HOLD)
//   is_shift    : true for modes allowed to start a counted shift
//   mode_to_sel : maps a mode onto the per-bit mux select
//
// Configuration macro: USR_ROTATE_EN
//   defined   -> ROTL/ROTR rotate and may start a counted shift
//   undefined -> ROTL/ROTR behave as HOLD and cannot start a counted shift
// -----------------------------------------------------------------------------
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROTL = 3'd4,
        MODE_ROTR = 3'd5
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // SEL_FROM_LO: bit i takes bit i-1 (the whole word moves towards the MSB).
    // SEL_FROM_HI: bit i takes bit i+1 (the whole word moves towards the LSB).
    typedef enum logic [1:0] {
        SEL_HOLD    = 2'd0,
        SEL_LOAD    = 2'd1,
        SEL_FROM_LO = 2'd2,
        SEL_FROM_HI = 2'd3
    } sel_t;

    // Codes 6 and 7 are reserved and act as HOLD.
    function automatic mode_t decode_mode(input logic [2:0] raw);
        mode_t m;
        case (raw)
            3'd1:    m = MODE_LOAD;
            3'd2:    m = MODE_SHL;
            3'd3:    m = MODE_SHR;
            3'd4:    m = MODE_ROTL;
            3'd5:    m = MODE_ROTR;
            default: m = MODE_HOLD;
        endcase
        return m;
    endfunction

    function automatic bit is_shift(input mode_t m);
        bit r;
        case (m)
            MODE_SHL,
            MODE_SHR:  r = 1'b1;
`ifdef USR_ROTATE_EN
            MODE_ROTL,
            MODE_ROTR: r = 1'b1;
`endif
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    // Rotation reuses the shift datapath; only the bit filling the vacated
    // end differs, and that is chosen at the top level.
    function automatic sel_t mode_to_sel(input mode_t m);
        sel_t s;
        case (m)
            MODE_LOAD: s = SEL_LOAD;
            MODE_SHL:  s = SEL_FROM_LO;
            MODE_SHR:  s = SEL_FROM_HI;
`ifdef USR_ROTATE_EN
            MODE_ROTL: s = SEL_FROM_LO;
            MODE_ROTR: s = SEL_FROM_HI;
`endif
            default:   s = SEL_HOLD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/usr_cell.sv
// -----------------------------------------------------------------------------
// usr_cell
// One bit of the universal shift register: a 4:1 next-value mux feeding an
// asynchronously reset flop.
//
// Ports
//   clk     in  1     rising-edge clock
//   rst     in  1     asynchronous, active-high reset (clears the bit)
//   sel_i   in  sel_t next-value select (hold / load / from lower / from upper)
//   load_i  in  1     parallel-load value for this bit
//   lo_i    in  1     value from the lower neighbour (or serial/rotate fill)
//   hi_i    in  1     value from the upper neighbour (or serial/rotate fill)
//   q_o     out 1     current bit value
// -----------------------------------------------------------------------------
module usr_cell
    import usr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  sel_t sel_i,
    input  logic load_i,
    input  logic lo_i,
    input  logic hi_i,
    output logic q_o
);

    logic bit_q;
    logic bit_d;

    always_comb begin
        // NOTE: assign a default before the case so every path drives bit_d
        // and no latch is inferred.
        bit_d = bit_q;
        case (sel_i)
            SEL_LOAD:    bit_d = load_i;
            SEL_FROM_LO: bit_d = lo_i;
            SEL_FROM_HI: bit_d = hi_i;
            default:     bit_d = bit_q;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q_o = bit_q;

endmodule

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
// Parametrised universal register: hold, parallel load, shift left/right with
// serial in/out, optional rotate, plus an automatic counted shift for
// serialising words (start + count -> busy, then a one-cycle done pulse).
//
// Parameters
//   WIDTH   register width in bits (>= 2), default 8
//   CNT_W   width of count, $clog2(WIDTH+1); derived, not overridable
//
// Ports
//   clk     in  1      rising-edge clock
//   rst     in  1      asynchronous, active-high reset
//   mode    in  3      0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROTL, 5 ROTR, 6/7 HOLD
//   p_in    in  WIDTH  parallel load data
//   sin_l   in  1      serial in for SHL, enters bit 0
//   sin_r   in  1      serial in for SHR, enters bit WIDTH-1
//   start   in  1      request a counted shift (sampled only in IDLE)
//   count   in  CNT_W  number of counted shifts
//   p_out   out WIDTH  register contents
//   sout_l  out 1      p_out[WIDTH-1]
//   sout_r  out 1      p_out[0]
//   busy    out 1      high while a counted shift is running
//   done    out 1      one-cycle pulse after a counted shift (or no-op start)
//
// Configuration macro: USR_ROTATE_EN (enables ROTL/ROTR; otherwise they HOLD)
// -----------------------------------------------------------------------------
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] p_in,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] p_out,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    // -------------------------------------------------------------------------
    // Controller state
    // -------------------------------------------------------------------------
    state_t           state_q,    state_d;
    mode_t            run_mode_q, run_mode_d;
    logic [CNT_W-1:0] rem_q,      rem_d;
    logic             done_q,     done_d;

    mode_t            in_mode;
    mode_t            eff_mode;
    sel_t             sel;
    logic             fill_lo;
    logic             fill_hi;
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] lo_nb;
    logic [WIDTH-1:0] hi_nb;

    assign in_mode = decode_mode(mode);

    // The mode actually applied to the datapath this edge. A start request in
    // IDLE freezes the register for that edge; in RUN the latched mode wins
    // and the live mode input is ignored.
    always_comb begin
        eff_mode = MODE_HOLD;
        if (state_q == ST_RUN) begin
            eff_mode = run_mode_q;
        end else if (!start) begin
            eff_mode = in_mode;
        end
    end

    assign sel = mode_to_sel(eff_mode);

    // Fill bits for the vacated end: serial inputs for shifts, the opposite
    // end of the word for rotates. sin_l/sin_r stay live during RUN.
    always_comb begin
        fill_lo = sin_l;
        fill_hi = sin_r;
`ifdef USR_ROTATE_EN
        if (eff_mode == MODE_ROTL) begin
            fill_lo = reg_q[WIDTH-1];
        end
        if (eff_mode == MODE_ROTR) begin
            fill_hi = reg_q[0];
        end
`endif
    end

    assign lo_nb = {reg_q[WIDTH-2:0], fill_lo};
    assign hi_nb = {fill_hi, reg_q[WIDTH-1:1]};

    // -------------------------------------------------------------------------
    // Datapath: one cell per bit
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        usr_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .sel_i  (sel),
            .load_i (p_in[i]),
            .lo_i   (lo_nb[i]),
            .hi_i   (hi_nb[i]),
            .q_o    (reg_q[i])
        );
    end

    // -------------------------------------------------------------------------
    // Counted-shift FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        run_mode_d = run_mode_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift(in_mode) && (count != '0)) begin
                        state_d    = ST_RUN;
                        run_mode_d = in_mode;
                        rem_d      = count;
                    end else begin
                        // Nothing to shift: acknowledge immediately.
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            run_mode_q <= MODE_HOLD;
            rem_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_mode_q <= run_mode_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all taken straight from flops)
    // -------------------------------------------------------------------------
    assign p_out  = reg_q;
    assign sout_l = reg_q[WIDTH-1];
    assign sout_r = reg_q[0];
    assign busy   = (state_q == ST_RUN);
    assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg
// Self-checking bench for universal_shift_reg (WIDTH = 8). A driver applies
// directed and random stimulus, advances a behavioural model and queues the
// expected outputs; a monitor pops and compares on every falling edge.
// Honours USR_ROTATE_EN the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_universal_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic [2:0]       mode;
    logic [WIDTH-1:0] p_in;
    logic             sin_l;
    logic             sin_r;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] p_out;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    universal_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .p_in   (p_in),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .start  (start),
        .count  (count),
        .p_out  (p_out),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0] p;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb_q[$];

    // -------------------------------------------------------------------------
    // Behavioural model: the register as an integer, a counted job as
    // "shifts still to do", arithmetic for each operation.
    // -------------------------------------------------------------------------
    int m_reg;
    int m_rem;
    int m_lmode;
    bit m_busy;
    bit m_done;

    function automatic bit can_run(input int md);
`ifdef USR_ROTATE_EN
        return (md >= 2) && (md <= 5);
`else
        return (md == 2) || (md == 3);
`endif
    endfunction

    function automatic int next_value(input int md, input int r, input int d, input int sl, input int sr);
        int v;
        case (md)
            1:       v = d;
            2:       v = (r * 2 + sl) % 256;
            3:       v = r / 2 + sr * 128;
`ifdef USR_ROTATE_EN
            4:       v = (r * 2 + r / 128) % 256;
            5:       v = r / 2 + (r % 2) * 128;
`endif
            default: v = r;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_reg   = 0;
        m_rem   = 0;
        m_lmode = 0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic model_step();
        bit nd;
        nd = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (m_busy) begin
                m_reg = next_value(m_lmode, m_reg, int'(p_in), int'(sin_l), int'(sin_r));
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    nd     = 1'b1;
                end
            end else if (start) begin
                if (can_run(int'(mode)) && (count != 0)) begin
                    m_busy  = 1'b1;
                    m_lmode = int'(mode);
                    m_rem   = int'(count);
                end else begin
                    nd = 1'b1;
                end
            end else begin
                m_reg = next_value(int'(mode), m_reg, int'(p_in), int'(sin_l), int'(sin_r));
            end
            m_done = nd;
        end
    endtask

    // One clock: step the model at the edge, queue its view, return at the
    // falling edge where inputs may be changed safely.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        model_step();
        e.p    = m_reg[7:0];
        e.busy = m_busy;
        e.done = m_done;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [2:0] md, input logic [7:0] d, input logic st, input logic [3:0] cnt);
        mode  = md;
        p_in  = d;
        start = st;
        count = cnt;
    endtask

    // -------------------------------------------------------------------------
    // Monitor: compares every queued expectation at the falling edge
    // -------------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_p_out",  32'(p_out),  32'(e.p));
                check("sb_sout_l", 32'(sout_l), 32'(e.p[7]));
                check("sb_sout_r", 32'(sout_r), 32'(e.p[0]));
                check("sb_busy",   32'(busy),   32'(e.busy));
                check("sb_done",   32'(done),   32'(e.done));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [7:0] sout_seq;
        int         drain;

        rst   = 1'b1;
        sin_l = 1'b0;
        sin_r = 1'b0;
        set_in(3'd0, 8'h00, 1'b0, 4'd0);
        model_reset();
        tick();
        tick();
        check("reset_p_out", 32'(p_out), 32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        check("reset_done",  32'(done),  32'h0);
        rst = 1'b0;
        tick();

        // Asynchronous reset in the middle of a counted shift.
        set_in(3'd1, 8'hFF, 1'b0, 4'd0);
        tick();
        sin_l = 1'b1;
        set_in(3'd2, 8'h00, 1'b1, 4'd8);
        tick();
        set_in(3'd0, 8'h00, 1'b0, 4'd0);
        tick();
        check("midrun_busy",  32'(busy),  32'h1);
        check("midrun_p_out", 32'(p_out), 32'hFF);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_p_out", 32'(p_out), 32'h0);
        check("async_rst_busy",  32'(busy),  32'h0);
        check("async_rst_done",  32'(done),  32'h0);
        model_reset();
        tick();
        rst   = 1'b0;
        sin_l = 1'b0;
        tick();
        tick();

        // Load then hold; p_in changes must not leak through.
        set_in(3'd1, 8'hA5, 1'b0, 4'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(3'd0, 8'($urandom), 1'b0, 4'd0);
            tick();
            check("hold_p_out",  32'(p_out),  32'hA5);
            check("hold_sout_l", 32'(sout_l), 32'h1);
            check("hold_sout_r", 32'(sout_r), 32'h1);
        end

        // Single shifts with serial fill.
        set_in(3'd1, 8'h81, 1'b0, 4'd0);
        tick();
        sin_l = 1'b0;
        set_in(3'd2, 8'h00, 1'b0, 4'd0);
        tick();
        check("shl_p_out", 32'(p_out), 32'h02);
        sin_r = 1'b1;
        set_in(3'd3, 8'h00, 1'b0, 4'd0);
        tick();
        tick();
        check("shr_p_out", 32'(p_out), 32'hC0);

        // Counted SHR of 0xB4 by 8, serialising LSB first.
        set_in(3'd1, 8'hB4, 1'b0, 4'd0);
        tick();
        sin_r = 1'b0;
        set_in(3'd3, 8'h00, 1'b1, 4'd8);
        tick();
        sout_seq = 8'hB4;
        for (int i = 0; i < 8; i++) begin
            check("cnt_busy",   32'(busy),   32'h1);
            check("cnt_sout_r", 32'(sout_r), 32'(sout_seq[i]));
            check("cnt_done",   32'(done),   32'h0);
            // Toggle mode/p_in and poke start mid-run; all must be ignored.
            set_in(3'($urandom_range(0, 7)), 8'($urandom), (i == 3), 4'($urandom_range(1, 8)));
            tick();
        end
        check("cnt_end_p_out", 32'(p_out), 32'h0);
        check("cnt_end_busy",  32'(busy),  32'h0);
        check("cnt_end_done",  32'(done),  32'h1);
        set_in(3'd0, 8'h00, 1'b0, 4'd0);
        tick();
        check("cnt_done_pulse", 32'(done), 32'h0);

        // No-op starts: zero count, then a non-shift mode.
        set_in(3'd2, 8'h00, 1'b1, 4'd0);
        tick();
        set_in(3'd0, 8'h00, 1'b0, 4'd0);
        check("noop0_busy", 32'(busy),  32'h0);
        check("noop0_done", 32'(done),  32'h1);
        check("noop0_reg",  32'(p_out), 32'h0);
        tick();
        check("noop0_done_clr", 32'(done), 32'h0);
        set_in(3'd1, 8'h5A, 1'b1, 4'd3);
        tick();
        set_in(3'd0, 8'h00, 1'b0, 4'd0);
        check("noopld_busy", 32'(busy),  32'h0);
        check("noopld_done", 32'(done),  32'h1);
        check("noopld_reg",  32'(p_out), 32'h0);
        tick();

        // Back-to-back: a start during the done cycle is accepted.
        set_in(3'd1, 8'h3C, 1'b0, 4'd0);
        tick();
        sin_l = 1'b1;
        set_in(3'd2, 8'h00, 1'b1, 4'd2);
        tick();
        set_in(3'd0, 8'h00, 1'b0, 4'd0);
        tick();
        tick();
        check("b2b_done", 32'(done), 32'h1);
        set_in(3'd3, 8'h00, 1'b1, 4'd1);
        tick();
        set_in(3'd0, 8'h00, 1'b0, 4'd0);
        check("b2b_busy", 32'(busy), 32'h1);
        tick();
        tick();

        // Rotate (or HOLD when rotation is not built in).
        set_in(3'd1, 8'h81, 1'b0, 4'd0);
        tick();
        set_in(3'd4, 8'h00, 1'b0, 4'd0);
        tick();
`ifdef USR_ROTATE_EN
        check("rotl_p_out", 32'(p_out), 32'h03);
`else
        check("rotl_p_out", 32'(p_out), 32'h81);
`endif
        set_in(3'd4, 8'h00, 1'b1, 4'd2);
        tick();
        set_in(3'd0, 8'h00, 1'b0, 4'd0);
        tick();
        tick();
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            sin_l = 1'($urandom);
            sin_r = 1'($urandom);
            set_in(3'($urandom_range(0, 7)), 8'($urandom),
                   ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
            tick();
        end

        set_in(3'd0, 8'h00, 1'b0, 4'd0);
        for (int n = 0; n < 20; n++) begin
            tick();
        end

        drain = 0;
        while ((sb_q.size() > 0) && (drain < 10)) begin
            @(negedge clk);
            drain++;
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
